palindrome_monitor: RTL and testbench
=====================================

# palindrome_monitor

Downstream statistics stage for the 3-bit serial palindrome detector. Consumes the detector's per-cycle `palindrome_o` flag and measures it over a fixed window of WINDOW cycles, started on command. At the end of each window it reports the number of flagged cycles and the longest run of consecutive flagged cycles, with a one-cycle completion pulse. Results are held until the next window completes.

## Interface
- WINDOW, default 16: cycles per measurement window; legal range 2..255.
- CNT_W, default $clog2(WINDOW+1): width of the result counters; derived, not overridden.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- start_i  input  1  request to start a window; level-sampled.
- palindrome_i  input  1  flag from the palindrome detector, sampled every cycle.
- busy_o  output  1  high while a window is in progress (MEASURE).
- done_o  output  1  one-cycle pulse (DONE state); results valid from this cycle.
- count_o  output  CNT_W  number of flagged cycles in the last completed window.
- max_run_o  output  CNT_W  longest run of consecutive flagged cycles in the last completed window.

## Operation
- FSM states: IDLE, MEASURE, DONE. Reset state is IDLE.
- IDLE:
  - start_i=1 → MEASURE.
  - Clear the sample counter `idx`, the accumulator `acc`, the current-run counter `run` and the running maximum `mx`.
- MEASURE: at each edge, sample palindrome_i as p.
  - acc += p.
  - run_n = p ? run+1 : 0.
  - mx = max(mx, run_n).
  - idx += 1.
- Last sample of a window (idx == WINDOW-1):
  - Load count_o/max_run_o with the values that include this sample.
  - Go to DONE.
  - Before this edge, count_o/max_run_o are unchanged.
- DONE: lasts exactly one cycle, with done_o=1.
  - start_i=1 → MEASURE, with all accumulators cleared (back-to-back windows).
  - Otherwise → IDLE.
- start_i in MEASURE is ignored; it does not restart or extend the window.
- Arithmetic:
  - acc, run and mx never exceed WINDOW, so there is no saturation and no wrap.
  - CNT_W guarantees count_o can represent the value WINDOW.
- Invariant: max_run_o ≤ count_o ≤ WINDOW. When count_o == WINDOW, max_run_o == WINDOW.
- Reset at any time, including mid-window:
  - FSM → IDLE.
  - busy_o=0, done_o=0.
  - count_o=0, max_run_o=0.
  - All internal counters cleared.
  - The partial window is discarded.
- No knowledge of detector fill latency: the flags from the detector's first two cycles after its own reset are counted as presented (they are 0).

## Timing
- Reset values: busy_o=0, done_o=0, count_o=0, max_run_o=0.
- Window timing, with start_i high at edge t0 in IDLE:
  - busy_o is high from t0+1 through the cycle before edge t0+WINDOW.
  - palindrome_i is sampled at edges t0+1 … t0+WINDOW.
  - done_o is high between edges t0+WINDOW and t0+WINDOW+1.
  - count_o/max_run_o are valid in the same cycle as done_o.
- Latency from start to done_o: WINDOW+1 cycles.
- Back-to-back: start_i held high gives windows every WINDOW+1 cycles; the DONE cycle is never sampled.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset/idle:** assert reset mid-cycle, then hold start_i=0 for 20 cycles → all outputs 0 and busy_o=0 throughout.
- **All-ones window:** WINDOW=16, palindrome_i=1 constantly, pulse start_i at t0 → done_o at t0+16, count_o=16, max_run_o=16, done_o width exactly 1.
- **Mixed pattern:** WINDOW=16, samples 1,1,0,1,1,1,0,0,1,0,1,1,1,1,0,1 → count_o=11, max_run_o=4. Repeat with the last sample being the end of the longest run (…0,1,1,1,1,1) to check that the final sample is included in max_run_o.
- **Start ignored while busy:** pulse start_i at t0 and again at t0+5 → single done_o at t0+16, no restart, and the results match the samples from t0+1 onward.
- **Back-to-back windows:** hold start_i=1 through two windows, with window A all 0 and window B alternating 1,0 → first done_o reports count_o=0, max_run_o=0. Second done_o, 17 cycles later, reports count_o=8, max_run_o=1. Between the two done_o pulses, outputs hold window A's values.
- **Reset mid-window:** start a window, feed 1s, assert reset at t0+8 → outputs clear immediately (asynchronously) and no done_o appears. A fresh start then yields a clean window result.

Source files
------------

// File: rtl/palindrome_monitor.sv
// rtl/palindrome_monitor.sv - windowed statistics (flag count, longest run) over the palindrome detector flag
module palindrome_monitor #(
  parameter int WINDOW = 16,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             palindrome_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] max_run_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] mx_q, mx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] max_run_q, max_run_d;

  // Statistics including the sample presented at this edge.
  logic [CNT_W-1:0] acc_n, run_n, mx_n;

  assign acc_n = acc_q + {{(CNT_W-1){1'b0}}, palindrome_i};
  assign run_n = palindrome_i ? (run_q + ONE) : '0;
  assign mx_n  = (run_n > mx_q) ? run_n : mx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    run_d     = run_q;
    mx_d      = mx_q;
    count_d   = count_q;
    max_run_d = max_run_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        acc_d = '0;
        run_d = '0;
        mx_d  = '0;
        if (start_i) state_d = MEASURE;
      end
      MEASURE: begin
        idx_d = idx_q + ONE;
        acc_d = acc_n;
        run_d = run_n;
        mx_d  = mx_n;
        if (idx_q == LAST_IDX) begin
          count_d   = acc_n;
          max_run_d = mx_n;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Clearing here lets a held start_i begin the next window immediately.
        idx_d   = '0;
        acc_d   = '0;
        run_d   = '0;
        mx_d    = '0;
        state_d = start_i ? MEASURE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      run_q     <= '0;
      mx_q      <= '0;
      count_q   <= '0;
      max_run_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      run_q     <= run_d;
      mx_q      <= mx_d;
      count_q   <= count_d;
      max_run_q <= max_run_d;
    end
  end

  assign busy_o    = (state_q == MEASURE);
  assign done_o    = (state_q == DONE);
  assign count_o   = count_q;
  assign max_run_o = max_run_q;

endmodule

// File: tb/tb_palindrome_monitor.sv
// tb/tb_palindrome_monitor.sv - directed self-checking bench for palindrome_monitor
module tb_palindrome_monitor;

  localparam int W = 16;

  logic       clk;
  logic       reset;
  logic       start_i;
  logic       palindrome_i;
  logic       busy_o;
  logic       done_o;
  logic [4:0] count_o;
  logic [4:0] max_run_o;

  int total = 0;
  int bad   = 0;

  palindrome_monitor #(.WINDOW(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .palindrome_i(palindrome_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .count_o     (count_o),
    .max_run_o   (max_run_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one window with sample k at edge t0+1+k; optional extra start pulse at edge t0+extra.
  task automatic drive_window(input logic [0:15] seq, input int extra,
                              output int done_edge, output int done_pulses,
                              output int busy_bad, output logic [4:0] cnt,
                              output logic [4:0] mx, output int hold_bad);
    done_edge = -1; done_pulses = 0; busy_bad = 0; hold_bad = 0;
    cnt = 'x; mx = 'x;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = (extra == 1);
    palindrome_i = seq[0];
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      start_i = (k + 1 == extra);
      palindrome_i = (k < W) ? seq[k] : 1'b0;
      if (k < W && busy_o !== 1'b1) busy_bad++;
      if (k >= W && busy_o !== 1'b0) busy_bad++;
      if (done_o === 1'b1) begin
        done_pulses++;
        done_edge = k;
        cnt = count_o;
        mx = max_run_o;
      end else if (done_pulses > 0 && (count_o !== cnt || max_run_o !== mx)) begin
        hold_bad++;
      end
    end
  endtask

  task automatic test_reset;
    int bad_cycles;
    reset = 1'b0; start_i = 1'b0; palindrome_i = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    total++;
    if ({busy_o, done_o, count_o, max_run_o} !== 12'd0) begin
      bad++; $display("FAIL reset_async: busy=%b done=%b count=%0d max=%0d want all 0", busy_o, done_o, count_o, max_run_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      palindrome_i = i[0];
      @(posedge clk); #1;
      if ({busy_o, done_o, count_o, max_run_o} !== 12'd0) bad_cycles++;
    end
    total++;
    if (bad_cycles !== 0) begin
      bad++; $display("FAIL idle_hold: %0d cycles with nonzero outputs, want 0", bad_cycles);
    end
  endtask

  task automatic check_window(input string name, input logic [0:15] seq, input int extra,
                              input logic [4:0] exp_cnt, input logic [4:0] exp_mx);
    int de, dp, bb, hb;
    logic [4:0] c, m;
    drive_window(seq, extra, de, dp, bb, c, m, hb);
    total++;
    if (dp !== 1) begin
      bad++; $display("FAIL %s_done_pulses: got %0d want 1", name, dp);
    end
    total++;
    if (de !== W) begin
      bad++; $display("FAIL %s_done_edge: got t0+%0d want t0+%0d", name, de, W);
    end
    total++;
    if (bb !== 0) begin
      bad++; $display("FAIL %s_busy: %0d bad cycles want 0", name, bb);
    end
    total++;
    if (c !== exp_cnt) begin
      bad++; $display("FAIL %s_count: got %0d want %0d", name, c, exp_cnt);
    end
    total++;
    if (m !== exp_mx) begin
      bad++; $display("FAIL %s_max_run: got %0d want %0d", name, m, exp_mx);
    end
    total++;
    if (hb !== 0) begin
      bad++; $display("FAIL %s_hold: %0d cycles results changed after done, want 0", name, hb);
    end
  endtask

  task automatic test_all_ones;
    check_window("all_ones", 16'b1111111111111111, -1, 5'd16, 5'd16);
  endtask

  task automatic test_mixed;
    check_window("mixed", 16'b1101110010111101, -1, 5'd11, 5'd4);
  endtask

  task automatic test_final_run;
    check_window("final_run", 16'b1011001000011111, -1, 5'd9, 5'd5);
  endtask

  task automatic test_start_ignored;
    check_window("start_busy", 16'b0000111111100001, 5, 5'd8, 5'd7);
  endtask

  task automatic test_back_to_back;
    int dp, e1, e2, hold_bad;
    logic [4:0] c1, m1, c2, m2;
    dp = 0; e1 = -1; e2 = -1; hold_bad = 0;
    c1 = 'x; m1 = 'x; c2 = 'x; m2 = 'x;
    @(posedge clk); #1;
    start_i = 1'b1;
    palindrome_i = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start_i = (k < 20);
      palindrome_i = (k + 1 >= 18 && k + 1 <= 33) ? ((k + 1 - 18) % 2 == 0) : 1'b0;
      if (done_o === 1'b1) begin
        dp++;
        if (dp == 1) begin e1 = k; c1 = count_o; m1 = max_run_o; end
        else begin e2 = k; c2 = count_o; m2 = max_run_o; end
      end else if (dp == 1 && (count_o !== 5'd0 || max_run_o !== 5'd0)) begin
        hold_bad++;
      end
    end
    total++;
    if (dp !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", dp); end
    total++;
    if (e1 !== 16 || e2 !== 33) begin
      bad++; $display("FAIL b2b_edges: got t0+%0d,t0+%0d want t0+16,t0+33", e1, e2);
    end
    total++;
    if (c1 !== 5'd0 || m1 !== 5'd0) begin
      bad++; $display("FAIL b2b_window_a: count=%0d max=%0d want 0,0", c1, m1);
    end
    total++;
    if (c2 !== 5'd8 || m2 !== 5'd1) begin
      bad++; $display("FAIL b2b_window_b: count=%0d max=%0d want 8,1", c2, m2);
    end
    total++;
    if (hold_bad !== 0) begin
      bad++; $display("FAIL b2b_hold: %0d cycles changed between pulses, want 0", hold_bad);
    end
  endtask

  task automatic test_reset_mid_window;
    int dones;
    @(posedge clk); #1;
    start_i = 1'b1;
    palindrome_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({busy_o, done_o, count_o, max_run_o} !== 12'd0) begin
      bad++; $display("FAIL midreset_clear: busy=%b done=%b count=%0d max=%0d want all 0", busy_o, done_o, count_o, max_run_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL midreset_no_done: %0d cycles busy/done after reset, want 0", dones);
    end
    check_window("after_reset", 16'b1101110010111101, -1, 5'd11, 5'd4);
  endtask

  initial begin
    reset = 1'b0;
    start_i = 1'b0;
    palindrome_i = 1'b0;
    test_reset;
    test_all_ones;
    test_mixed;
    test_final_run;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_window;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
